instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter DEPTH, default 2, instruction buffer entries and maximum outstanding memory requests.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 imem_req  out  1  fetch request valid.
REQ-006 imem_addr  out  32  fetch address, word-aligned.
REQ-007 imem_gnt  in  1  request accepted this cycle when imem_req=1.
REQ-008 imem_rvalid  in  1  read data returning; responses in request order.
REQ-009 imem_rdata  in  32  instruction word.
REQ-010 redirect_valid  in  1  taken branch/jump; discard all in-flight work.
REQ-011 redirect_pc  in  32  new fetch address.
REQ-012 instr_valid  out  1  buffer head valid toward decode.
REQ-013 instr_ready  in  1  decode consumes head when instr_valid=1.
REQ-014 instr, instr_pc  out  32 each  head instruction word and its address.
REQ-015 op_code, func3, func7  out  7/3/7  instr[6:0], instr[14:12], instr[31:25] for the control decoder.

Function
REQ-016 FSM states BOOT, RUN, DRAIN; BOOT lasts exactly one cycle after reset release, then RUN.
REQ-017 imem_addr always equals the PC register; imem_req=1 only in RUN when (outstanding + buffer occupancy) < DEPTH.
REQ-018 Request handshake: imem_req & imem_gnt increments outstanding and advances PC by 4; PC 32'hFFFF_FFFC wraps to 32'h0.
REQ-019 imem_rvalid in RUN pushes {imem_rdata, address} into the buffer and decrements outstanding; instr_pc is the address originally requested.
REQ-020 Credit rule guarantees no overflow; push and pop in the same cycle are both honoured, including when full.
REQ-021 imem_rvalid with outstanding=0 is a protocol error; the response is ignored and no counter underflows.
REQ-022 redirect_valid: same cycle, buffer flushed next edge, PC <= {redirect_pc[31:2],2'b00}, instr_valid=0 next cycle.
REQ-023 On redirect, stale count <= outstanding (plus 1 if a grant occurs in the same cycle); if stale count>0 go DRAIN, else RUN.
REQ-024 DRAIN: imem_req=0, each imem_rvalid discarded and stale count decremented; at zero return to RUN next cycle.
REQ-025 Redirect during DRAIN: PC reloaded, stale count unchanged except for the same-cycle rvalid decrement.
REQ-026 Redirect has priority over a same-cycle pop; the popped instruction is still considered consumed by decode.
REQ-027 Latency: gnt at cycle N, rvalid at M ≥ N+1 -> instr_valid=1 at M+1 (registered buffer).

Reset
REQ-028 Asserted rst_n=0: PC=RESET_PC, state BOOT, outstanding=0, stale=0, buffer empty, imem_req=0, instr_valid=0, instr=32'h0000_0013 (NOP), instr_pc=RESET_PC.
REQ-029 Reset mid-operation abandons all in-flight requests; responses arriving after release with outstanding=0 fall under REQ-021.

Structure
REQ-030 Shared package rv32_pkg holds the opcode constants (LOAD 7'b0000011, STORE 7'b0100011, OP 7'b0110011), NOP encoding, XLEN=32, and the fetch FSM state enum.
REQ-031 Buffer is sub-module fetch_fifo (DEPTH entries, 64-bit payload, push/pop/flush, count output); FSM, PC and counters stay in instr_fetch.

Verification
REQ-032 Reset release, gnt=1, rvalid one cycle later with 0x00A00093, 0x00000013 -> addresses 0x0,0x4,0x8 requested; instr_valid at cycle 3 with instr_pc=0x0.
REQ-033 instr_ready=0, DEPTH=2 -> after two grants imem_req=0 stays low; one pop -> exactly one new request.
REQ-034 Two outstanding, redirect to 0x0000_0103 -> next addr 0x100, two rvalids discarded in DRAIN, then RUN fetches 0x100.
REQ-035 PC at 0xFFFF_FFFC granted -> next imem_addr 0x0.
REQ-036 Simultaneous rvalid, pop on full buffer and grant -> occupancy unchanged, no lost or duplicated instruction.
REQ-037 rst_n low mid-DRAIN -> all outputs at REQ-028 values asynchronously; stray rvalid after release ignored.

Source files
------------

// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared RV32 constants, fetch FSM state type and helpers
package rv32_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FS_BOOT  = 2'd0,
        FS_RUN   = 2'd1,
        FS_DRAIN = 2'd2
    } fetch_state_e;

    // Fetch addresses are always word aligned; low two bits are dropped.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - instruction buffer with push/pop/flush and occupancy count
module fetch_fifo #(
    parameter int  DEPTH = 2,
    parameter int  WIDTH = 64,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_pop;
    logic             do_push;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A push into a full buffer is accepted only when the head leaves in the same cycle.
    assign do_pop  = pop && (count_q != '0);
    assign do_push = push && ((count_q != CW'(DEPTH)) || do_pop);

    // Next pointer/count/storage; flush empties the buffer and wins over push/pop.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Buffer storage and pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign empty     = (count_q == '0);
    assign count     = count_q;

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - credit-based instruction fetch unit with redirect and drain
module instr_fetch
    import rv32_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [6:0]      op_code,
    output logic [2:0]      func3,
    output logic [6:0]      func7
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = CW + 1;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]   outst_q, outst_d;
    logic [CW-1:0]   stale_q, stale_d;

    logic [CW-1:0]     fifo_count;
    logic [2*XLEN-1:0] fifo_head;
    logic              fifo_empty;
    logic              credit_ok;
    logic              fire;
    logic              rv_live;
    logic              rv_stale;
    logic              pop;
    logic              push;

    // Every in-flight request reserves a buffer slot, so the buffer can never overflow.
    assign credit_ok = ({1'b0, outst_q} + {1'b0, fifo_count}) < SW'(DEPTH);
    assign fire      = imem_req && imem_gnt;
    // A response with nothing outstanding is a protocol error and is dropped.
    assign rv_live   = imem_rvalid && (state_q == FS_RUN) && (outst_q != '0);
    assign rv_stale  = imem_rvalid && (state_q == FS_DRAIN) && (stale_q != '0);
    assign pop       = instr_ready && !fifo_empty;
    // A redirect flushes the buffer, so a same-cycle response must not land in it.
    assign push      = rv_live && !redirect_valid;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2 * XLEN)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({imem_rdata, resp_pc_q}),
        .pop       (pop),
        .flush     (redirect_valid),
        .head_data (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // State register: FSM state, fetch PC, response PC and request counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FS_BOOT;
            pc_q      <= RESET_PC;
            resp_pc_q <= RESET_PC;
            outst_q   <= '0;
            stale_q   <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            resp_pc_q <= resp_pc_d;
            outst_q   <= outst_d;
            stale_q   <= stale_d;
        end
    end

    // Next state: count requests/responses, convert live requests to stale ones on redirect.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        resp_pc_d = resp_pc_q;
        outst_d   = outst_q;
        stale_d   = stale_q;
        case (state_q)
            FS_BOOT: begin
                state_d = FS_RUN;
            end
            FS_RUN: begin
                if (redirect_valid) begin
                    // Whatever is still in flight after this cycle must be thrown away.
                    stale_d = outst_q + CW'(fire) - CW'(rv_live);
                    outst_d = '0;
                    state_d = (stale_d != '0) ? FS_DRAIN : FS_RUN;
                end else begin
                    outst_d = outst_q + CW'(fire) - CW'(rv_live);
                    if (fire) begin
                        pc_d = pc_q + 32'd4;
                    end
                    if (rv_live) begin
                        resp_pc_d = resp_pc_q + 32'd4;
                    end
                end
            end
            FS_DRAIN: begin
                stale_d = stale_q - CW'(rv_stale);
                if (stale_d == '0) begin
                    state_d = FS_RUN;
                end
            end
            default: begin
                state_d = FS_BOOT;
            end
        endcase
        // The first response after a redirect (once stale ones are gone) belongs to the new PC.
        if (redirect_valid) begin
            pc_d      = word_align(redirect_pc);
            resp_pc_d = word_align(redirect_pc);
        end
    end

    // Outputs: request only in RUN with a free credit; empty buffer presents a NOP.
    always_comb begin
        imem_req    = (state_q == FS_RUN) && credit_ok;
        imem_addr   = pc_q;
        instr_valid = !fifo_empty;
        instr       = fifo_empty ? NOP_INSTR : fifo_head[2*XLEN-1:XLEN];
        instr_pc    = fifo_empty ? RESET_PC : fifo_head[XLEN-1:0];
    end

    assign op_code = instr[6:0];
    assign func3   = instr[14:12];
    assign func7   = instr[31:25];

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - randomized and directed self-checking bench for instr_fetch
module tb_instr_fetch;
    import rv32_pkg::*;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [6:0]  op_code;
    logic [2:0]  func3;
    logic [6:0]  func7;

    instr_fetch #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .op_code        (op_code),
        .func3          (func3),
        .func7          (func7)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int dut_grants = 0;

    // Reference model: live request addresses, stale count, decode-side buffer.
    bit          m_boot;
    logic [31:0] m_pc;
    int          m_stale;
    logic [31:0] m_live[$];
    logic [63:0] m_buf[$];
    logic [31:0] mem_pend[$];

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_req();
        return !m_boot && (m_stale == 0) && ((m_live.size() + m_buf.size()) < DEPTH);
    endfunction

    task automatic model_reset();
        m_boot  = 1'b1;
        m_pc    = RESET_PC;
        m_stale = 0;
        m_live.delete();
        m_buf.delete();
        mem_pend.delete();
    endtask

    task automatic check_outputs();
        logic [63:0] head;
        chk_eq("imem_req", 32'(imem_req), 32'(model_req()));
        chk_eq("imem_addr", imem_addr, m_pc);
        chk_eq("instr_valid", 32'(instr_valid), 32'(m_buf.size() > 0));
        if (m_buf.size() > 0) begin
            head = m_buf[0];
            chk_eq("instr", instr, head[63:32]);
            chk_eq("instr_pc", instr_pc, head[31:0]);
            chk_eq("op_code", 32'(op_code), 32'(head[38:32]));
            chk_eq("func3", 32'(func3), 32'(head[46:44]));
            chk_eq("func7", 32'(func7), 32'(head[63:57]));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk_eq({tag, "_req"}, 32'(imem_req), 32'd0);
        chk_eq({tag, "_addr"}, imem_addr, RESET_PC);
        chk_eq({tag, "_valid"}, 32'(instr_valid), 32'd0);
        chk_eq({tag, "_instr"}, instr, 32'h0000_0013);
        chk_eq({tag, "_pc"}, instr_pc, RESET_PC);
        chk_eq({tag, "_opc"}, 32'(op_code), 32'h13);
    endtask

    // Drops reset away from a clock edge, checks asynchronous effect, then releases.
    task automatic apply_reset();
        #2;
        rst_n          = 1'b0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        redirect_valid = 1'b0;
        instr_ready    = 1'b0;
        #1;
        check_reset_outputs("rst");
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        model_reset();
        #1;
        check_reset_outputs("rel");
    endtask

    // One clock: drive inputs, advance the model, then compare after the edge.
    task automatic step(input bit g, input bit rv, input logic [31:0] rd,
                        input bit redir, input logic [31:0] rpc, input bit rdy);
        bit          fire;
        bit          pop;
        bit          rv_live;
        bit          rv_stale;
        logic [63:0] ent;
        imem_gnt       = g;
        imem_rvalid    = rv;
        imem_rdata     = rd;
        redirect_valid = redir;
        redirect_pc    = rpc;
        instr_ready    = rdy;
        fire     = model_req() && g;
        pop      = rdy && (m_buf.size() > 0);
        rv_stale = rv && (m_stale > 0);
        rv_live  = rv && (m_stale == 0) && (m_live.size() > 0);
        ent      = '0;
        if (rv && mem_pend.size() > 0) void'(mem_pend.pop_front());
        if (fire) mem_pend.push_back(m_pc);
        if (rv_live) ent = {rd, m_live.pop_front()};
        if (fire) m_live.push_back(m_pc);
        if (rv_stale) m_stale--;
        if (redir) begin
            m_stale += m_live.size();
            m_live.delete();
            m_buf.delete();
            m_pc = {rpc[31:2], 2'b00};
        end else begin
            if (pop) void'(m_buf.pop_front());
            if (rv_live) m_buf.push_back(ent);
            if (fire) m_pc = m_pc + 32'd4;
        end
        m_boot = 1'b0;
        #1;
        if (imem_req && imem_gnt) dut_grants++;
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    initial begin
        bit          g;
        bit          rv;
        bit          redir;
        bit          rdy;
        logic [31:0] rpc;

        model_reset();
        apply_reset();

        // Basic fetch: grants back to back, responses one cycle later.
        step(1, 0, 0, 0, 0, 0);
        chk_eq("b_addr0", imem_addr, 32'h0);
        chk_eq("b_req0", 32'(imem_req), 32'd1);
        step(1, 0, 0, 0, 0, 0);
        chk_eq("b_addr4", imem_addr, 32'h4);
        step(1, 1, 32'h00A0_0093, 0, 0, 0);
        chk_eq("b_valid3", 32'(instr_valid), 32'd1);
        chk_eq("b_pc3", instr_pc, 32'h0);
        chk_eq("b_instr3", instr, 32'h00A0_0093);
        chk_eq("b_addr8", imem_addr, 32'h8);
        step(1, 1, 32'h0000_0013, 0, 0, 1);
        chk_eq("b_pc4", instr_pc, 32'h4);

        // Back-pressure: two credits used, requests stop until one pop.
        apply_reset();
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 32'h1111_1111, 0, 0, 0);
        step(1, 1, 32'h2222_2222, 0, 0, 0);
        dut_grants = 0;
        repeat (4) step(1, 0, 0, 0, 0, 0);
        chk_eq("bp_nogrant", 32'(dut_grants), 32'd0);
        step(1, 0, 0, 0, 0, 1);
        repeat (4) step(1, 0, 0, 0, 0, 0);
        chk_eq("bp_onegrant", 32'(dut_grants), 32'd1);

        // Redirect with two outstanding: drain both, then fetch the new target.
        apply_reset();
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 32'h0000_0103, 0);
        chk_eq("rd_addr", imem_addr, 32'h100);
        chk_eq("rd_req", 32'(imem_req), 32'd0);
        step(0, 1, 32'hDEAD_0001, 0, 0, 1);
        chk_eq("rd_drop1", 32'(instr_valid), 32'd0);
        step(0, 1, 32'hDEAD_0002, 0, 0, 1);
        chk_eq("rd_drop2", 32'(instr_valid), 32'd0);
        chk_eq("rd_run_req", 32'(imem_req), 32'd1);
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 32'h0000_0033, 0, 0, 0);
        chk_eq("rd_pc", instr_pc, 32'h100);

        // PC wrap at the top of the address space.
        apply_reset();
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'hFFFF_FFFC, 0);
        chk_eq("wr_addr_top", imem_addr, 32'hFFFF_FFFC);
        step(1, 0, 0, 0, 0, 0);
        chk_eq("wr_addr0", imem_addr, 32'h0);
        step(0, 1, 32'h0000_0003, 0, 0, 0);
        chk_eq("wr_pc", instr_pc, 32'hFFFF_FFFC);

        // Push and pop together: occupancy held, order kept.
        apply_reset();
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 32'hAAAA_0001, 0, 0, 0);
        step(1, 1, 32'hAAAA_0002, 0, 0, 1);
        chk_eq("pp_valid", 32'(instr_valid), 32'd1);
        chk_eq("pp_pc", instr_pc, 32'h4);
        chk_eq("pp_instr", instr, 32'hAAAA_0002);
        step(0, 0, 0, 0, 0, 1);
        chk_eq("pp_empty", 32'(instr_valid), 32'd0);

        // Reset while draining; stray responses afterwards are ignored.
        apply_reset();
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'h0000_0200, 0);
        chk_eq("dr_addr", imem_addr, 32'h200);
        apply_reset();
        step(0, 1, 32'h5555_5555, 0, 0, 0);
        step(0, 1, 32'h6666_6666, 0, 0, 0);
        chk_eq("stray_valid", 32'(instr_valid), 32'd0);
        step(0, 0, 0, 0, 0, 0);
        chk_eq("stray_valid2", 32'(instr_valid), 32'd0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) apply_reset();
            g     = ($urandom_range(0, 3) != 0);
            rv    = (mem_pend.size() > 0) ? ($urandom_range(0, 2) != 0)
                                          : ($urandom_range(0, 39) == 0);
            redir = ($urandom_range(0, 24) == 0);
            rpc   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF4 : 32'($urandom);
            rdy   = ($urandom_range(0, 2) != 0);
            step(g, rv, 32'($urandom), redir, rpc, rdy);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
